// File: rtl/uart_axi_master_pkg.sv
// uart_axi_master_pkg: command/response bytes and FSM encoding for the UART AXI-Lite bridge
package uart_axi_master_pkg;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, AW_W, B, AR, R, SEND} state_t;
endpackage

// File: rtl/uart_axi_resp_serializer.sv
// uart_axi_resp_serializer: shifts a 1- or 4-byte response into the TX FIFO, MSB first
module uart_axi_resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        four,
    input  logic [31:0] data,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr_uart,
    output logic        done
);
    logic [31:0] sr;
    logic [2:0]  left;
    assign w_data  = sr[31:24];
    assign wr_uart = left != 3'd0 && !tx_full;
    assign done    = wr_uart && left == 3'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            left <= '0;
        end else if (load) begin
            sr   <= data;
            left <= four ? 3'd4 : 3'd1;
        end else if (wr_uart) begin
            sr   <= {sr[23:0], 8'h00};
            left <= left - 3'd1;
        end
    end
endmodule

// File: rtl/uart_axi_lite_master.sv
// uart_axi_lite_master: UART byte-command bridge issuing single AXI-Lite reads and writes
module uart_axi_lite_master
    import uart_axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RX_TIMEOUT = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_empty,
    input  logic [7:0]              r_data,
    output logic                    rd_uart,
    input  logic                    tx_full,
    output logic [7:0]              w_data,
    output logic                    wr_uart,
    output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
    output logic                    o_axi_awvalid,
    input  logic                    i_axi_awready,
    output logic [DATA_WIDTH-1:0]   o_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
    output logic                    o_axi_wvalid,
    input  logic                    i_axi_wready,
    input  logic                    i_axi_bvalid,
    output logic                    o_axi_bready,
    output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
    output logic                    o_axi_arvalid,
    input  logic                    i_axi_arready,
    input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
    input  logic                    i_axi_rvalid,
    output logic                    o_axi_rready
);
    localparam int TW = $clog2(RX_TIMEOUT);
    localparam logic [TW-1:0] T_MAX = TW'(RX_TIMEOUT - 1);
    state_t                  state;
    logic                    op_write;
    logic [1:0]              cnt;
    logic [TW-1:0]           timer;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    ser_load, ser_four, ser_done;
    logic [31:0]             ser_data;
    assign rd_uart      = !reset && !rx_empty && (state == IDLE || state == GET_ADDR || state == GET_DATA);
    assign o_axi_wstrb  = '1;
    assign o_axi_awaddr = addr;
    assign o_axi_araddr = addr;
    always_comb begin
        ser_load = (state == IDLE && rd_uart && r_data != CMD_WRITE && r_data != CMD_READ)
                || (state == B && i_axi_bvalid) || (state == R && i_axi_rvalid);
        ser_four = state == R;
        ser_data = state == R ? i_axi_rdata : {state == B ? RSP_OK : RSP_ERR, 24'h0};
    end
    uart_axi_resp_serializer u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .four    (ser_four),
        .data    (ser_data),
        .tx_full (tx_full),
        .w_data  (w_data),
        .wr_uart (wr_uart),
        .done    (ser_done)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_write      <= 1'b0;
            cnt           <= '0;
            timer         <= '0;
            addr          <= '0;
            o_axi_wdata   <= '0;
            o_axi_awvalid <= 1'b0;
            o_axi_wvalid  <= 1'b0;
            o_axi_bready  <= 1'b0;
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_uart) begin
                    op_write <= r_data == CMD_WRITE;
                    cnt      <= '0;
                    timer    <= '0;
                    state    <= (r_data == CMD_WRITE || r_data == CMD_READ) ? GET_ADDR : SEND;
                end
                GET_ADDR: if (rd_uart) begin
                    addr  <= {addr[ADDR_WIDTH-9:0], r_data};
                    cnt   <= cnt + 2'd1;
                    timer <= '0;
                    if (cnt == 2'd3) begin
                        state         <= op_write ? GET_DATA : AR;
                        o_axi_arvalid <= !op_write;
                    end
                end else if (timer == T_MAX) state <= IDLE;
                else timer <= timer + TW'(1);
                GET_DATA: if (rd_uart) begin
                    o_axi_wdata <= {o_axi_wdata[DATA_WIDTH-9:0], r_data};
                    cnt         <= cnt + 2'd1;
                    timer       <= '0;
                    if (cnt == 2'd3) begin
                        state         <= AW_W;
                        o_axi_awvalid <= 1'b1;
                        o_axi_wvalid  <= 1'b1;
                    end
                end else if (timer == T_MAX) state <= IDLE;
                else timer <= timer + TW'(1);
                AW_W: begin
                    // each channel drops on its own handshake; move on once neither is pending
                    o_axi_awvalid <= o_axi_awvalid && !i_axi_awready;
                    o_axi_wvalid  <= o_axi_wvalid && !i_axi_wready;
                    if ((!o_axi_awvalid || i_axi_awready) && (!o_axi_wvalid || i_axi_wready)) begin
                        state        <= B;
                        o_axi_bready <= 1'b1;
                    end
                end
                B: if (i_axi_bvalid) begin
                    o_axi_bready <= 1'b0;
                    state        <= SEND;
                end
                AR: if (i_axi_arready) begin
                    o_axi_arvalid <= 1'b0;
                    o_axi_rready  <= 1'b1;
                    state         <= R;
                end
                R: if (i_axi_rvalid) begin
                    o_axi_rready <= 1'b0;
                    state        <= SEND;
                end
                SEND: if (ser_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
